// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: I2C target front-end driving the one-hot register-port bus
// (PORT_CS / OFFSET_SEL / RD_WR / DIN / DOUT).
// Optional feature macro: I2C_TIMEOUT_EN. When defined, a transfer is aborted
// after SCL has been held low for TIMEOUT_CYCLES system clocks.
module i2c_reg_bridge #(
   parameter logic [6:0]  DEV_ADDR       = 7'h40
`ifdef I2C_TIMEOUT_EN
  ,parameter logic [19:0] TIMEOUT_CYCLES = 20'd250000
`endif
) (
   input  logic        SYSCLK,
   input  logic        RESET_N,
   input  logic        SCL_IN,
   input  logic        SDA_IN,
   output logic        SDA_OE,
   output logic        PORT_CS,
   output logic [15:0] OFFSET_SEL,
   output logic        RD_WR,
   output logic [7:0]  DIN,
   input  logic [7:0]  DOUT,
   output logic        BUSY
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      PTR       = 4'd3,
      PTR_ACK   = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RACK      = 4'd8,
      WAIT_STOP = 4'd9
   } state_t;

   // line conditioning
   logic        scl_meta_r, scl_sync_r, scl_prev_r;
   logic        sda_meta_r, sda_sync_r, sda_prev_r;
   logic        scl_rise_s, scl_fall_s, start_s, stop_s, abort_s;

   // FSM
   state_t      state_r, state_nxt_s;
   logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic [6:0]  rx_r, rx_nxt_s;
   logic [7:0]  rx_byte_s;
   logic        rw_r, rw_nxt_s;
   logic        sda_oe_r, sda_oe_nxt_s;
   logic        ptr_load_s, wr_stb_s, rd_stb_s, rd_ack_s, tx_shift_s, clr_s;

   // register-port datapath
   logic [3:0]  ptr_r;
   logic [15:0] offset_sel_r;
   logic        port_cs_r, rd_wr_r, ld_r, busy_r;
   logic [7:0]  din_r, tx_r;
   logic [1:0]  rd_req_r;

   assign scl_rise_s = scl_sync_r & ~scl_prev_r;
   assign scl_fall_s = ~scl_sync_r & scl_prev_r;
   assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
   assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
   assign rx_byte_s  = {rx_r, sda_sync_r};

   // Two-flop synchronisers plus a history flop for edge detection.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         scl_meta_r <= 1'b1;
         scl_sync_r <= 1'b1;
         scl_prev_r <= 1'b1;
         sda_meta_r <= 1'b1;
         sda_sync_r <= 1'b1;
         sda_prev_r <= 1'b1;
      end else begin
         scl_meta_r <= SCL_IN;
         scl_sync_r <= scl_meta_r;
         scl_prev_r <= scl_sync_r;
         sda_meta_r <= SDA_IN;
         sda_sync_r <= sda_meta_r;
         sda_prev_r <= sda_sync_r;
      end
   end

`ifdef I2C_TIMEOUT_EN
   logic [19:0] to_cnt_r;

   // Count SYSCLK cycles of SCL-low while a transfer is in progress.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         to_cnt_r <= 20'd0;
      end else if (scl_sync_r || !busy_r || abort_s) begin
         to_cnt_r <= 20'd0;
      end else begin
         to_cnt_r <= to_cnt_r + 20'd1;
      end
   end

   assign abort_s = busy_r & ~scl_sync_r & (to_cnt_r >= (TIMEOUT_CYCLES - 20'd1));
`else
   assign abort_s = 1'b0;
`endif

   // FSM state and bit-level registers.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         rx_r      <= 7'd0;
         rw_r      <= 1'b0;
         sda_oe_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         rx_r      <= rx_nxt_s;
         rw_r      <= rw_nxt_s;
         sda_oe_r  <= sda_oe_nxt_s;
      end
   end

   // Next-state logic: sample on SCL rise, drive SDA on SCL fall; bus
   // conditions override bit events.
   always_comb begin
      state_nxt_s   = state_r;
      bit_cnt_nxt_s = bit_cnt_r;
      rx_nxt_s      = rx_r;
      rw_nxt_s      = rw_r;
      sda_oe_nxt_s  = sda_oe_r;
      ptr_load_s    = 1'b0;
      wr_stb_s      = 1'b0;
      rd_stb_s      = 1'b0;
      rd_ack_s      = 1'b0;
      tx_shift_s    = 1'b0;
      clr_s         = 1'b0;
      if (start_s) begin
         state_nxt_s   = ADDR;
         bit_cnt_nxt_s = 3'd0;
         sda_oe_nxt_s  = 1'b0;
         clr_s         = 1'b1;
      end else if (stop_s || abort_s) begin
         state_nxt_s   = IDLE;
         bit_cnt_nxt_s = 3'd0;
         sda_oe_nxt_s  = 1'b0;
         clr_s         = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               sda_oe_nxt_s = 1'b0;
            end
            ADDR, PTR, WDATA: begin
               if (scl_rise_s) begin
                  rx_nxt_s      = rx_byte_s[6:0];
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     if (state_r == ADDR) begin
                        if (rx_byte_s[7:1] == DEV_ADDR) begin
                           state_nxt_s = ADDR_ACK;
                           rw_nxt_s    = rx_byte_s[0];
                        end else begin
                           state_nxt_s = WAIT_STOP;
                        end
                     end else if (state_r == PTR) begin
                        state_nxt_s = PTR_ACK;
                        ptr_load_s  = 1'b1;
                     end else begin
                        state_nxt_s = WDATA_ACK;
                        wr_stb_s    = 1'b1;
                     end
                  end else begin
                     state_nxt_s = state_r;
                  end
               end else if (scl_fall_s) begin
                  // first fall in a byte also ends the previous ACK
                  sda_oe_nxt_s = 1'b0;
               end else begin
                  sda_oe_nxt_s = sda_oe_r;
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall_s) begin
                  sda_oe_nxt_s = 1'b1;
               end else if (scl_rise_s) begin
                  bit_cnt_nxt_s = 3'd0;
                  if (state_r == ADDR_ACK && rw_r) begin
                     state_nxt_s = RDATA;
                     rd_stb_s    = 1'b1;
                  end else if (state_r == ADDR_ACK) begin
                     state_nxt_s = PTR;
                  end else begin
                     state_nxt_s = WDATA;
                  end
               end else begin
                  sda_oe_nxt_s = sda_oe_r;
               end
            end
            RDATA: begin
               if (scl_fall_s) begin
                  sda_oe_nxt_s = ~tx_r[7];
                  tx_shift_s   = 1'b1;
               end else if (scl_rise_s) begin
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_nxt_s = RACK;
                  end else begin
                     state_nxt_s = RDATA;
                  end
               end else begin
                  sda_oe_nxt_s = sda_oe_r;
               end
            end
            RACK: begin
               if (scl_fall_s) begin
                  sda_oe_nxt_s = 1'b0;
               end else if (scl_rise_s) begin
                  if (!sda_sync_r) begin
                     state_nxt_s = RDATA;
                     rd_ack_s    = 1'b1;
                  end else begin
                     state_nxt_s = WAIT_STOP;
                  end
               end else begin
                  sda_oe_nxt_s = sda_oe_r;
               end
            end
            WAIT_STOP: begin
               sda_oe_nxt_s = 1'b0;
            end
            default: begin
               state_nxt_s  = IDLE;
               sda_oe_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // Register-port initiator: pointer, one-hot decode, strobes, read capture.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ptr_r        <= 4'h0;
         offset_sel_r <= 16'h0001;
         port_cs_r    <= 1'b0;
         rd_wr_r      <= 1'b1;
         din_r        <= 8'h00;
         tx_r         <= 8'h00;
         rd_req_r     <= 2'b00;
         ld_r         <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         offset_sel_r <= 16'd1 << ptr_r;
         busy_r       <= (state_nxt_s != IDLE);
         // port DOUT is valid the cycle after a read strobe
         ld_r         <= port_cs_r & rd_wr_r & ~clr_s;
         if (ld_r) begin
            tx_r <= DOUT;
         end else if (tx_shift_s) begin
            tx_r <= {tx_r[6:0], 1'b0};
         end
         // host ACK: bump pointer, let OFFSET_SEL settle, then strobe
         if (clr_s) begin
            rd_req_r <= 2'b00;
         end else begin
            rd_req_r <= {rd_req_r[0], rd_ack_s};
         end
         if (ptr_load_s) begin
            ptr_r <= rx_byte_s[3:0];
         end else if (rd_ack_s || (port_cs_r && !rd_wr_r)) begin
            ptr_r <= ptr_r + 4'd1;
         end
         port_cs_r <= 1'b0;
         if (!port_cs_r && !clr_s) begin
            if (wr_stb_s) begin
               port_cs_r <= 1'b1;
               rd_wr_r   <= 1'b0;
               din_r     <= rx_byte_s;
            end else if (rd_stb_s || (rd_req_r[1] && state_r == RDATA)) begin
               port_cs_r <= 1'b1;
               rd_wr_r   <= 1'b1;
            end
         end
      end
   end

   assign SDA_OE     = sda_oe_r;
   assign PORT_CS    = port_cs_r;
   assign OFFSET_SEL = offset_sel_r;
   assign RD_WR      = rd_wr_r;
   assign DIN        = din_r;
   assign BUSY       = busy_r;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge: bit-banged I2C host, register-port model and a
// reference model of the pointer/register file for i2c_reg_bridge.
`timescale 1ns/1ps
module tb_i2c_reg_bridge;

   logic        SYSCLK = 1'b0;
   logic        RESET_N;
   logic        scl_host, sda_host;
   logic        sda_line;
   logic        SDA_OE, PORT_CS, RD_WR, BUSY;
   logic [15:0] OFFSET_SEL;
   logic [7:0]  DIN, DOUT;

   assign sda_line = sda_host & ~SDA_OE;

   i2c_reg_bridge #(
      .DEV_ADDR(7'h40)
`ifdef I2C_TIMEOUT_EN
     ,.TIMEOUT_CYCLES(20'd100)
`endif
   ) dut (
      .SYSCLK(SYSCLK), .RESET_N(RESET_N), .SCL_IN(scl_host), .SDA_IN(sda_line),
      .SDA_OE(SDA_OE), .PORT_CS(PORT_CS), .OFFSET_SEL(OFFSET_SEL), .RD_WR(RD_WR),
      .DIN(DIN), .DOUT(DOUT), .BUSY(BUSY)
   );

   always #5 SYSCLK = ~SYSCLK;

   // register-port model: registered read data, write on strobe
   logic [7:0] port_mem [16];

   function automatic int onehot_idx(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge SYSCLK) begin
      if (PORT_CS) begin
         if (RD_WR) DOUT <= port_mem[onehot_idx(OFFSET_SEL)];
         else       port_mem[onehot_idx(OFFSET_SEL)] <= DIN;
      end
   end

   // bus monitor
   int          oe_cnt, cs_double, cs_idle;
   bit          prev_cs;
   logic [15:0] log_off [$];
   logic        log_rw  [$];
   logic [7:0]  log_din [$];

   always @(negedge SYSCLK) begin
      if (SDA_OE === 1'b1) oe_cnt <= oe_cnt + 1;
      if (PORT_CS && prev_cs) cs_double <= cs_double + 1;
      if (PORT_CS && !BUSY) cs_idle <= cs_idle + 1;
      prev_cs <= PORT_CS;
      if (PORT_CS) begin
         log_off.push_back(OFFSET_SEL);
         log_rw.push_back(RD_WR);
         log_din.push_back(DIN);
      end
   end

   // reference model
   logic [7:0] ref_mem [16];
   logic [3:0] ref_ptr;
   logic [7:0] wbuf [16];
   int n_checks = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge SYSCLK);
   endtask

   task automatic i2c_start();
      sda_host = 1'b0; cyc(10);
      scl_host = 1'b0; cyc(10);
   endtask

   task automatic i2c_rep_start();
      sda_host = 1'b1; cyc(10);
      scl_host = 1'b1; cyc(10);
      sda_host = 1'b0; cyc(10);
      scl_host = 1'b0; cyc(10);
   endtask

   task automatic i2c_stop();
      sda_host = 1'b0; cyc(10);
      scl_host = 1'b1; cyc(10);
      sda_host = 1'b1; cyc(20);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_host = b[i]; cyc(10);
         scl_host = 1'b1; cyc(20);
         scl_host = 1'b0; cyc(10);
      end
      sda_host = 1'b1; cyc(10);
      scl_host = 1'b1; cyc(10);
      ack = ~sda_line; cyc(10);
      scl_host = 1'b0; cyc(10);
   endtask

   task automatic clk_bit(output logic v);
      cyc(10);
      scl_host = 1'b1; cyc(10);
      v = sda_line; cyc(10);
      scl_host = 1'b0;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] b);
      logic v;
      sda_host = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(v);
         b[i] = v;
         cyc(10);
      end
      sda_host = nack; cyc(10);
      scl_host = 1'b1; cyc(20);
      scl_host = 1'b0; cyc(10);
      sda_host = 1'b1;
   endtask

   task automatic do_write(input logic [3:0] p, input int n);
      logic ack;
      logic [3:0] hi;
      int base;
      base = log_off.size();
      hi = 4'($urandom_range(0, 15));
      i2c_start();
      send_byte(8'h80, ack);        chk("wr_addr_ack", ack, 1);
      send_byte({hi, p}, ack);      chk("wr_ptr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         send_byte(wbuf[i], ack);   chk($sformatf("wr_data_ack[%0d]", i), ack, 1);
      end
      i2c_stop();
      chk("wr_strobes", log_off.size() - base, n);
      for (int i = 0; i < n; i++) begin
         logic [3:0] a;
         a = 4'((p + i) % 16);
         if (base + i < log_off.size()) begin
            chk($sformatf("wr_rdwr[%0d]", i), log_rw[base + i], 0);
            chk($sformatf("wr_off[%0d]", i), log_off[base + i], 32'd1 << a);
            chk($sformatf("wr_din[%0d]", i), log_din[base + i], wbuf[i]);
         end
         ref_mem[a] = wbuf[i];
      end
      ref_ptr = 4'((p + n) % 16);
      chk("wr_off_after", OFFSET_SEL, 32'd1 << ref_ptr);
      chk("wr_busy_after", BUSY, 0);
   endtask

   task automatic do_read(input logic set_ptr, input logic [3:0] p, input int n);
      logic ack;
      logic [7:0] b;
      int base;
      base = log_off.size();
      i2c_start();
      if (set_ptr) begin
         send_byte(8'h80, ack);     chk("rd_waddr_ack", ack, 1);
         send_byte({4'h0, p}, ack); chk("rd_ptr_ack", ack, 1);
         ref_ptr = p;
         i2c_rep_start();
      end
      send_byte(8'h81, ack);        chk("rd_addr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, b);
         chk($sformatf("rd_data[%0d]", i), b, ref_mem[4'((ref_ptr + i) % 16)]);
      end
      i2c_stop();
      chk("rd_strobes", log_off.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < log_off.size()) begin
            chk($sformatf("rd_rdwr[%0d]", i), log_rw[base + i], 1);
            chk($sformatf("rd_off[%0d]", i), log_off[base + i], 32'd1 << ((ref_ptr + i) % 16));
         end
      end
      ref_ptr = 4'((ref_ptr + n - 1) % 16);
      chk("rd_off_after", OFFSET_SEL, 32'd1 << ref_ptr);
      chk("rd_busy_after", BUSY, 0);
   endtask

   initial begin
      logic ack;
      logic v;
      logic [7:0] b;
      int base, oe_base;
      scl_host = 1'b1;
      sda_host = 1'b1;
      RESET_N  = 1'b0;
      cyc(4);
      chk("rst_sda_oe", SDA_OE, 0);
      chk("rst_port_cs", PORT_CS, 0);
      chk("rst_rd_wr", RD_WR, 1);
      chk("rst_din", DIN, 0);
      chk("rst_offset", OFFSET_SEL, 16'h0001);
      chk("rst_busy", BUSY, 0);
      RESET_N = 1'b1;
      cyc(10);
      chk("idle_offset", OFFSET_SEL, 16'h0001);
      chk("idle_busy", BUSY, 0);
      ref_ptr = 4'h0;

      // preload every register with random data (16-byte burst wraps to 0)
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      do_write(4'h0, 16);

      // directed single write
      wbuf[0] = 8'hA5;
      do_write(4'h3, 1);
      chk("wr_offset_0010", OFFSET_SEL, 16'h0010);

      // burst across the pointer wrap
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(4'hF, 2);
      chk("wrap_ptr_1", OFFSET_SEL, 16'h0002);

      // directed read: 0x5A at offset 2, then offset 3 (0xA5)
      wbuf[0] = 8'h5A;
      do_write(4'h2, 1);
      do_read(1'b1, 4'h2, 2);
      chk("rd_end_off", OFFSET_SEL, 16'h0008);

      // address mismatch
      base = log_off.size();
      oe_base = oe_cnt;
      i2c_start();
      send_byte(8'h90, ack); chk("mm_addr_ack", ack, 0);
      send_byte(8'h00, ack); chk("mm_data_ack", ack, 0);
      i2c_stop();
      chk("mm_oe_never", oe_cnt - oe_base, 0);
      chk("mm_no_strobe", log_off.size() - base, 0);

      // reset during the 5th data bit of a read returning 0x00
      wbuf[0] = 8'h00;
      do_write(4'h6, 1);
      i2c_start();
      send_byte(8'h80, ack);
      send_byte(8'h06, ack);
      i2c_rep_start();
      send_byte(8'h81, ack); chk("rr_addr_ack", ack, 1);
      for (int i = 0; i < 4; i++) begin
         clk_bit(v);
         chk($sformatf("rr_bit[%0d]", i), v, 0);
         cyc(10);
      end
      chk("rr_oe_before", SDA_OE, 1);
      RESET_N = 1'b0;
      #1;
      chk("rr_oe_now", SDA_OE, 0);
      chk("rr_offset", OFFSET_SEL, 16'h0001);
      chk("rr_busy", BUSY, 0);
      cyc(5);
      scl_host = 1'b1;
      sda_host = 1'b1;
      cyc(5);
      RESET_N = 1'b1;
      cyc(10);
      ref_ptr = 4'h0;
      do_read(1'b0, 4'h0, 1);
      wbuf[0] = 8'($urandom);
      do_write(4'h9, 1);
      do_read(1'b1, 4'h9, 1);

      // randomized traffic
      for (int it = 0; it < 6; it++) begin
         int n;
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         do_write(4'($urandom_range(0, 15)), n);
         do_read(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom_range(1, 3));
      end

`ifdef I2C_TIMEOUT_EN
      // SCL stuck low mid-byte
      base = log_off.size();
      i2c_start();
      send_byte(8'h80, ack);
      send_byte(8'h04, ack);
      ref_ptr = 4'h4;
      for (int i = 0; i < 3; i++) begin
         sda_host = 1'b1; cyc(10);
         scl_host = 1'b1; cyc(20);
         scl_host = 1'b0; cyc(10);
      end
      chk("to_busy_before", BUSY, 1);
      cyc(101);
      chk("to_busy", BUSY, 0);
      chk("to_sda_oe", SDA_OE, 0);
      chk("to_no_strobe", log_off.size() - base, 0);
      chk("to_ptr_kept", OFFSET_SEL, 16'h0010);
      i2c_stop();
      do_read(1'b0, 4'h0, 1);
`endif

      chk("cs_never_double", cs_double, 0);
      chk("cs_never_idle", cs_idle, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
- I2C target front-end that converts I2C transactions into the internal one-hot register-port bus (PORT_CS / OFFSET_SEL / RD_WR / DIN / DOUT) used by the status CPLD register blocks.
- Initiator side of that bus: issues write strobes and read strobes, and captures read data for transmission back to the I2C host.
- Sits between the board I2C pins and one register port.

Parameters:
DEV_ADDR, 7'h40, 7-bit I2C target address.
TIMEOUT_CYCLES, 20'd250000, SYSCLK cycles of continuous SCL-low before forced abort (optional feature only).

Ports:
SYSCLK  in  1  system clock; must be ≥ 20× SCL frequency.
RESET_N  in  1  asynchronous, active-low reset.
SCL_IN  in  1  I2C clock pin, asynchronous.
SDA_IN  in  1  I2C data pin, asynchronous.
SDA_OE  out  1  1 = pull SDA low (open-drain).
PORT_CS  out  1  one-cycle bus strobe.
OFFSET_SEL  out  16  one-hot register select = 1 << ptr.
RD_WR  out  1  1 = read, 0 = write; valid whenever PORT_CS = 1.
DIN  out  8  write data to the register port.
DOUT  in  8  read data from the register port; registered at the port, valid 1 cycle after a read strobe.
BUSY  out  1  high from START until STOP or abort.

Behaviour:
Reset values:
- SDA_OE = 0, PORT_CS = 0, RD_WR = 1, DIN = 8'h00, OFFSET_SEL = 16'h0001, BUSY = 0.
- ptr = 4'h0; FSM in IDLE.
- Reset asserted mid-transfer releases SDA immediately.

Line conditioning and bus events:
- SCL and SDA are each 2-flop synchronised, then edge-detected on the synchronised values.
- START = SDA falling while SCL high. STOP = SDA rising while SCL high.
- SDA is sampled on SCL rising edges; SDA_OE changes only on SCL falling edges.
- START (including repeated START) from any state → ADDR, bit counter cleared, SDA_OE = 0.
- STOP from any state → IDLE, SDA_OE = 0.
- START/STOP take priority over a bit event in the same cycle.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- ADDR: shift 8 bits, MSB first.
  - Bits [7:1] == DEV_ADDR → ADDR_ACK; SDA_OE = 1 from the next SCL fall for one SCL period.
  - Mismatch → WAIT_STOP with no ACK.
- ADDR_ACK:
  - R/W = 0 → PTR.
  - R/W = 1 → read strobe issued on the SCL rise of the ACK bit (see Reads), then RDATA.
- PTR: shift 8 bits. ptr <= byte[3:0]; upper nibble is ignored. ACK → WDATA.
- WDATA: on the 8th SCL rise, the next SYSCLK cycle drives PORT_CS = 1, RD_WR = 0, DIN = byte for exactly 1 cycle.
  - Cycle after the strobe: ptr <= ptr + 1, wrapping F → 0.
  - ACK is always given → WDATA_ACK → WDATA.
- Reads:
  - Read strobe: PORT_CS = 1, RD_WR = 1 for 1 cycle, with OFFSET_SEL already stable.
  - Shift register loads DOUT 2 cycles after the strobe.
  - MSB is driven from the first SCL fall; bit driven as SDA_OE = ~bit.
- RDATA: after 8 bits → RACK, SDA released.
- RACK, host ACK (SDA = 0):
  - ptr <= ptr + 1; OFFSET_SEL updates 1 cycle later; read strobe 1 cycle after that; load 2 cycles after the strobe. Total 4 cycles, well inside the SCL high + low time.
  - → RDATA.
- RACK, host NACK → WAIT_STOP.
- WAIT_STOP: SDA_OE = 0; only START or STOP exits.

General rules:
- OFFSET_SEL is always a registered decode of ptr.
- ptr persists across transactions, so a read without a pointer write continues from the last pointer.
- PORT_CS never asserts for two consecutive cycles, and never in IDLE or WAIT_STOP.
- BUSY = 1 in any state other than IDLE.

Optional Feature:
I2C_TIMEOUT_EN
- Defined: a counter runs while synchronised SCL is low and BUSY = 1, and clears on SCL high.
  - Reaching TIMEOUT_CYCLES → SDA_OE = 0, FSM → IDLE, BUSY = 0; ptr unchanged.
  - No strobe is generated on abort.
- Undefined: no counter; stuck-low SCL holds the current state indefinitely.

Test Plan:
- Write: START, 0x80, 0x03, 0xA5, STOP → address, pointer and data bytes ACKed; single PORT_CS pulse with RD_WR = 0, OFFSET_SEL = 16'h0008, DIN = 8'hA5; OFFSET_SEL = 16'h0010 afterwards.
- Burst wrap: pointer 0x0F, data 0x11, 0x22 → strobes at OFFSET_SEL 16'h8000 then 16'h0001; ptr ends at 1.
- Read: port returns 8'h5A at offset 2. Write pointer 0x02, repeated START, 0x81, read 2 bytes (ACK then NACK), STOP → SDA carries 0x5A then the offset-3 value; two read strobes, at OFFSET_SEL 16'h0004 and 16'h0008.
- Address mismatch: START, 0x90, 0x00, STOP → no ACK on any bit, SDA_OE stays 0, PORT_CS never asserts.
- RESET_N pulled low during the 5th data bit of a read → SDA_OE = 0 at once; OFFSET_SEL = 16'h0001, BUSY = 0; next transaction completes normally.
- With I2C_TIMEOUT_EN, TIMEOUT_CYCLES = 100: hold SCL low 101 cycles mid-byte → BUSY falls, SDA_OE = 0, no strobe.
